// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the gate response checker: FSM states, gate bit
// positions and the golden truth-table function used by gate_golden.
package gate_response_checker_pkg;

  localparam int NUM_GATES = 7;

  // Bit positions inside the expected/observed/fail_mask vectors
  localparam int BIT_AND   = 0;
  localparam int BIT_NAND  = 1;
  localparam int BIT_OR    = 2;
  localparam int BIT_NOR   = 3;
  localparam int BIT_XOR   = 4;
  localparam int BIT_XNOR  = 5;
  localparam int BIT_NOT   = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [NUM_GATES-1:0] golden_vec(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g           = '0;
    g[BIT_AND]  = a & b;
    g[BIT_NAND] = ~(a & b);
    g[BIT_OR]   = a | b;
    g[BIT_NOR]  = ~(a | b);
    g[BIT_XOR]  = a ^ b;
    g[BIT_XNOR] = ~(a ^ b);
    g[BIT_NOT]  = ~a;
    return g;
  endfunction

endpackage

// File: rtl/gate_response_checker_golden.sv
// Golden model of the mux-built gate block: maps a,b to the seven expected
// gate outputs in fail_mask bit order. Purely combinational.
module gate_golden
  import gate_response_checker_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  always_comb begin
    expected = golden_vec(a, b);
  end

endmodule

// File: rtl/gate_response_checker.sv
// Self-check unit for the 2x1-mux gate block: accepts {s,a,b} vectors, waits a
// settle window, compares the gate outputs to gate_golden and tallies results.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             s,
  input  logic             andd,
  input  logic             nandd,
  input  logic             orr,
  input  logic             norr,
  input  logic             xorr,
  input  logic             xnorr,
  input  logic             nott,
  output logic             rdy,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       vec_cnt,
  output logic [2:0]       fail_idx,
  output logic [6:0]       fail_mask
);

  localparam logic [3:0] SETTLE_L  = 4'(SETTLE);
  localparam logic [7:0] NUM_VEC_L = 8'(NUM_VEC);

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             settle_cnt;
  logic [2:0]             vec_p0;
  logic [NUM_GATES-1:0]   expected;
  logic [NUM_GATES-1:0]   observed;
  logic [NUM_GATES-1:0]   mism;
  logic [7:0]             vec_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    if (&x) return x;
    return x + 1'b1;
  endfunction

  gate_golden u_golden (
    .a        (vec_p0[1]),
    .b        (vec_p0[0]),
    .expected (expected)
  );

  always_comb begin
    observed           = '0;
    observed[BIT_AND]  = andd;
    observed[BIT_NAND] = nandd;
    observed[BIT_OR]   = orr;
    observed[BIT_NOR]  = norr;
    observed[BIT_XOR]  = xorr;
    observed[BIT_XNOR] = xnorr;
    observed[BIT_NOT]  = nott;
    mism               = observed ^ expected;
    vec_inc            = vec_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start overrides every state, including a same-cycle vld in ARMED
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_ARMED;
    end else begin
      unique case (state)
        ST_IDLE:    state_nxt = ST_IDLE;
        ST_ARMED:   if (vld) state_nxt = (SETTLE_L == 4'd0) ? ST_COMPARE : ST_SETTLE;
        ST_SETTLE:  if (settle_cnt <= 4'd1) state_nxt = ST_COMPARE;
        ST_COMPARE: state_nxt = (vec_inc == NUM_VEC_L) ? ST_DONE : ST_ARMED;
        ST_DONE:    state_nxt = ST_DONE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_ARMED:   begin rdy = 1'b1; busy = 1'b1; end
      ST_SETTLE:  busy = 1'b1;
      ST_COMPARE: busy = 1'b1;
      ST_DONE:    done = 1'b1;
      default:    ;
    endcase
    pass = done & (err_cnt == '0);
  end

  // Gate outputs are only looked at in COMPARE, so glitches elsewhere are harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      vec_p0     <= '0;
      err_cnt    <= '0;
      vec_cnt    <= '0;
      fail_idx   <= '0;
      fail_mask  <= '0;
    end else if (start) begin
      err_cnt    <= '0;
      vec_cnt    <= '0;
      fail_idx   <= '0;
      fail_mask  <= '0;
    end else begin
      unique case (state)
        ST_ARMED: begin
          if (vld) begin
            vec_p0     <= {s, a, b};
            settle_cnt <= SETTLE_L;
          end
        end
        ST_SETTLE: settle_cnt <= settle_cnt - 4'd1;
        ST_COMPARE: begin
          vec_cnt <= vec_inc;
          if (mism != '0) begin
            err_cnt <= sat_inc(err_cnt);
            if (err_cnt == '0) begin
              fail_idx  <= vec_p0;
              fail_mask <= mism;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomised bench for gate_response_checker: two instances (SETTLE=1/CNT_W=4 and
// SETTLE=3/CNT_W=2) checked each cycle against a timing/count model, plus literal pins.
module tb_gate_response_checker;

  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      start_i, vld_i, a_i, b_i, s_i;
  logic [1:0][6:0] got_i;

  logic       rdy0, busy0, done0, pass0, rdy1, busy1, done1, pass1;
  logic [3:0] err0;
  logic [1:0] err1;
  logic [7:0] vec0, vec1;
  logic [2:0] fidx0, fidx1;
  logic [6:0] fmask0, fmask1;

  gate_response_checker #(.NUM_VEC(NV), .SETTLE(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .vld(vld_i[0]),
    .a(a_i[0]), .b(b_i[0]), .s(s_i[0]),
    .andd(got_i[0][0]), .nandd(got_i[0][1]), .orr(got_i[0][2]), .norr(got_i[0][3]),
    .xorr(got_i[0][4]), .xnorr(got_i[0][5]), .nott(got_i[0][6]),
    .rdy(rdy0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .vec_cnt(vec0), .fail_idx(fidx0), .fail_mask(fmask0));

  gate_response_checker #(.NUM_VEC(NV), .SETTLE(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .vld(vld_i[1]),
    .a(a_i[1]), .b(b_i[1]), .s(s_i[1]),
    .andd(got_i[1][0]), .nandd(got_i[1][1]), .orr(got_i[1][2]), .norr(got_i[1][3]),
    .xorr(got_i[1][4]), .xnorr(got_i[1][5]), .nott(got_i[1][6]),
    .rdy(rdy1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .vec_cnt(vec1), .fail_idx(fidx1), .fail_mask(fmask1));

  int n_chk = 0;
  int n_pass = 0;
  int fmode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] gold(input logic [2:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {~a, ~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
  endfunction

  function automatic logic [6:0] flip(input logic [6:0] g);
    case (fmode)
      0:       return 7'h00;
      1:       return g & 7'h10;
      2:       return 7'h7F;
      default: return ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
    endcase
  endfunction

  // Model: per instance, whether it waits for a vector, cycles left until the
  // compare cycle of a pending vector, whether the run finished, and the tallies.
  int         m_armed[2], m_pend[2], m_rem[2], m_fin[2];
  int         m_err[2], m_vec[2], m_fidx[2], m_fmask[2];
  logic [2:0] m_lat[2];
  int         setv[2]  = '{1, 3};
  int         errmax[2] = '{15, 3};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_armed[i] = 0; m_pend[i] = 0; m_rem[i] = 0; m_fin[i] = 0;
        m_err[i] = 0; m_vec[i] = 0; m_fidx[i] = 0; m_fmask[i] = 0; m_lat[i] = 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [6:0] mm;
        if (start_i[i]) begin
          m_err[i] = 0; m_vec[i] = 0; m_fidx[i] = 0; m_fmask[i] = 0;
          m_armed[i] = 1; m_pend[i] = 0; m_fin[i] = 0;
        end else if (m_pend[i] != 0 && m_rem[i] == 0) begin
          mm = got_i[i] ^ gold(m_lat[i]);
          if (mm != 7'h00) begin
            if (m_err[i] == 0) begin
              m_fidx[i]  = int'(m_lat[i]);
              m_fmask[i] = int'(mm);
            end
            m_err[i] = (m_err[i] + 1 > errmax[i]) ? errmax[i] : m_err[i] + 1;
          end
          m_vec[i]++;
          m_pend[i] = 0;
          if (m_vec[i] == NV) m_fin[i] = 1;
          else m_armed[i] = 1;
        end else if (m_pend[i] != 0) begin
          m_rem[i]--;
        end else if (m_armed[i] != 0 && vld_i[i]) begin
          m_lat[i]   = {s_i[i], a_i[i], b_i[i]};
          m_armed[i] = 0;
          m_pend[i]  = 1;
          m_rem[i]   = setv[i];
        end
      end
    end
  end

  // Gate block stand-in: true (possibly faulted) outputs in the compare cycle, noise otherwise
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_pend[i] != 0 && m_rem[i] == 0) got_i[i] = gold(m_lat[i]) ^ flip(gold(m_lat[i]));
      else got_i[i] = 7'($urandom);
    end
  end

  always @(negedge clk) begin
    chk("i0_rdy",   32'(rdy0),   32'(m_armed[0] != 0));
    chk("i0_busy",  32'(busy0),  32'(m_armed[0] != 0 || m_pend[0] != 0));
    chk("i0_done",  32'(done0),  32'(m_fin[0] != 0));
    chk("i0_pass",  32'(pass0),  32'(m_fin[0] != 0 && m_err[0] == 0));
    chk("i0_err",   32'(err0),   m_err[0]);
    chk("i0_vec",   32'(vec0),   m_vec[0]);
    chk("i0_fidx",  32'(fidx0),  m_fidx[0]);
    chk("i0_fmask", 32'(fmask0), m_fmask[0]);
    chk("i1_rdy",   32'(rdy1),   32'(m_armed[1] != 0));
    chk("i1_busy",  32'(busy1),  32'(m_armed[1] != 0 || m_pend[1] != 0));
    chk("i1_done",  32'(done1),  32'(m_fin[1] != 0));
    chk("i1_pass",  32'(pass1),  32'(m_fin[1] != 0 && m_err[1] == 0));
    chk("i1_err",   32'(err1),   m_err[1]);
    chk("i1_vec",   32'(vec1),   m_vec[1]);
    chk("i1_fidx",  32'(fidx1),  m_fidx[1]);
    chk("i1_fmask", 32'(fmask1), m_fmask[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i);
    start_i[i] = 1'b1;
    tick();
    start_i[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [2:0] v);
    int n;
    n = 0;
    while (m_armed[i] == 0 && n < 100) begin
      tick();
      n++;
    end
    chk("send_wait_bound", 32'(n < 100), 32'd1);
    {s_i[i], a_i[i], b_i[i]} = v;
    vld_i[i] = 1'b1;
    tick();
    vld_i[i] = 1'b0;
  endtask

  initial begin
    start_i = '0; vld_i = '0; a_i = '0; b_i = '0; s_i = '0;
    rst_n = 1'b0;
    tick();
    chk("rst_rdy0", 32'(rdy0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_vec1", 32'(vec1), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clean run, SETTLE=1: compare lands two edges after accept
    fmode = 0;
    do_start(0);
    send(0, 3'd0);
    chk("t1_rdy_settle", 32'(rdy0), 32'd0);
    tick();
    chk("t1_rdy_compare", 32'(rdy0), 32'd0);
    chk("t1_vec_before", 32'(vec0), 32'd0);
    tick();
    chk("t1_rdy_back", 32'(rdy0), 32'd1);
    chk("t1_vec_after", 32'(vec0), 32'd1);
    for (int v = 1; v < 8; v++) send(0, 3'(v));
    repeat (5) tick();
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_pass", 32'(pass0), 32'd1);
    chk("t1_err", 32'(err0), 32'd0);
    chk("t1_vec", 32'(vec0), 32'd8);

    // xorr stuck at 0
    fmode = 1;
    do_start(0);
    for (int v = 0; v < 8; v++) send(0, 3'(v));
    repeat (5) tick();
    chk("t2_err", 32'(err0), 32'd4);
    chk("t2_fidx", 32'(fidx0), 32'd1);
    chk("t2_fmask", 32'(fmask0), 32'h10);
    chk("t2_pass", 32'(pass0), 32'd0);
    chk("t2_done", 32'(done0), 32'd1);

    // All outputs inverted, CNT_W=2 saturates
    fmode = 2;
    do_start(1);
    for (int v = 0; v < 8; v++) send(1, 3'(v));
    repeat (8) tick();
    chk("t5_err", 32'(err1), 32'd3);
    chk("t5_fidx", 32'(fidx1), 32'd0);
    chk("t5_fmask", 32'(fmask1), 32'h7F);
    chk("t5_pass", 32'(pass1), 32'd0);

    // vld pulses during SETTLE=3 are ignored
    fmode = 0;
    do_start(1);
    send(1, 3'd5);
    vld_i[1] = 1'b1; tick();
    vld_i[1] = 1'b0; tick();
    vld_i[1] = 1'b1; tick();
    vld_i[1] = 1'b0;
    repeat (4) tick();
    chk("t3_vec", 32'(vec1), 32'd1);
    chk("t3_rdy", 32'(rdy1), 32'd1);

    // start during SETTLE of vector 3, then start+vld together in ARMED
    do_start(1);
    for (int v = 0; v < 4; v++) send(1, 3'(v));
    tick();
    start_i[1] = 1'b1; vld_i[1] = 1'b1;
    tick();
    start_i[1] = 1'b0; vld_i[1] = 1'b0;
    chk("t4_rdy", 32'(rdy1), 32'd1);
    chk("t4_vec", 32'(vec1), 32'd0);
    start_i[1] = 1'b1; vld_i[1] = 1'b1;
    tick();
    start_i[1] = 1'b0; vld_i[1] = 1'b0;
    chk("t4_drop_rdy", 32'(rdy1), 32'd1);
    repeat (6) tick();
    chk("t4_drop_vec", 32'(vec1), 32'd0);

    // Async reset in the middle of a settle window
    send(1, 3'd6);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy1", 32'(busy1), 32'd0);
    chk("t6_rdy1", 32'(rdy1), 32'd0);
    chk("t6_vec1", 32'(vec1), 32'd0);
    chk("t6_done0", 32'(done0), 32'd0);
    chk("t6_err0", 32'(err0), 32'd0);
    chk("t6_fmask0", 32'(fmask0), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    vld_i[1] = 1'b1;
    repeat (5) tick();
    vld_i[1] = 1'b0;
    chk("t6_idle_busy", 32'(busy1), 32'd0);
    chk("t6_idle_vec", 32'(vec1), 32'd0);

    // Random traffic on both instances
    do_start(0);
    do_start(1);
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) fmode = $urandom_range(0, 3);
      for (int i = 0; i < 2; i++) begin
        start_i[i] = ($urandom_range(0, 39) == 0);
        vld_i[i]   = 1'($urandom);
        a_i[i]     = 1'($urandom);
        b_i[i]     = 1'($urandom);
        s_i[i]     = 1'($urandom);
      end
      tick();
    end
    start_i = '0; vld_i = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
